// File: rtl/mac_sequencer_pkg.sv
// Shared widths and FSM encoding for the MAC sequencer and its write-back path.
// Imported by the interface, the requantizer and the sequencer top.
package mac_sequencer_pkg;

   localparam int MAC_W  = 20;
   localparam int DATA_W = 8;
   localparam int SEL_W  = 32;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ACCUM,
      ACTIVATE,
      WRITE,
      DONE
   } state_t;

endpackage

// File: rtl/mac_sequencer_if.sv
// Bundle of layer handshake, MAC datapath control and next-layer write port.
// master = sequencer side, slave = datapath/memory side.
interface mac_sequencer_if
   import mac_sequencer_pkg::*;
#(
   parameter int AW = 8
) ();

   logic              start;
   logic [MAC_W-1:0]  relu_in;
   logic [SEL_W-1:0]  input_sel;
   logic [AW-1:0]     neuron_sel;
   logic              rst_acc;
   logic              ld_acc;
   logic              ready;
   logic              busy;
   logic              done;
   logic              out_wr_en;
   logic [AW-1:0]     out_wr_addr;
   logic [DATA_W-1:0] out_wr_data;

   modport master (
      input  start, relu_in,
      output input_sel, neuron_sel, rst_acc, ld_acc, ready,
             busy, done, out_wr_en, out_wr_addr, out_wr_data
   );

   modport slave (
      output start, relu_in,
      input  input_sel, neuron_sel, rst_acc, ld_acc, ready,
             busy, done, out_wr_en, out_wr_addr, out_wr_data
   );

endinterface

// File: rtl/mac_sequencer_requant_sat.sv
// Requantizer: shifts a non-negative MAC result right and saturates it to an
// 8-bit sign-magnitude value with the sign bit forced to 0.
module requant_sat
   import mac_sequencer_pkg::*;
#(
   parameter int SHIFT = 7
) (
   input  logic [MAC_W-1:0]  x,
   output logic [DATA_W-1:0] data
);

   localparam logic [MAC_W-2:0] MAG_MAX = (MAC_W-1)'(2**(DATA_W-1) - 1);

   logic [MAC_W-2:0] s;
   logic             unused_sign;

   // The ReLU upstream guarantees a non-negative value, so the top bit carries no information.
   assign unused_sign = x[MAC_W-1];
   assign s           = x[MAC_W-2:0] >> SHIFT;
   assign data        = (s > MAG_MAX) ? {1'b0, MAG_MAX[DATA_W-2:0]}
                                      : {1'b0, s[DATA_W-2:0]};

endmodule

// File: rtl/mac_sequencer.sv
// Runs the MAC datapath one neuron at a time for M neurons and writes each
// requantized ReLU result into the next layer's input memory.
module mac_sequencer
   import mac_sequencer_pkg::*;
#(
   parameter int N     = 10,
   parameter int M     = 4,
   parameter int SHIFT = 7,
   parameter int AW    = 8
) (
   input logic             clk,
   input logic             rst,
   mac_sequencer_if.master bus
);

   state_t            state;
   logic [SEL_W-1:0]  k;
   logic [AW-1:0]     n;
   logic [MAC_W-1:0]  cap;
   logic              rst_acc_q;
   logic [DATA_W-1:0] q_data;

   requant_sat #(.SHIFT(SHIFT)) u_requant (
      .x    (cap),
      .data (q_data)
   );

   // The accumulator must clear in the same cycle the block is held in reset.
   assign bus.rst_acc     = rst_acc_q | rst;
   assign bus.out_wr_data = bus.out_wr_en ? q_data : '0;

   // NOTE: non-blocking assignments only, so every branch reads pre-edge register values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         k               <= '0;
         n               <= '0;
         cap             <= '0;
         rst_acc_q       <= 1'b0;
         bus.input_sel   <= '0;
         bus.neuron_sel  <= '0;
         bus.ld_acc      <= 1'b0;
         bus.ready       <= 1'b0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.out_wr_en   <= 1'b0;
         bus.out_wr_addr <= '0;
      end else begin
         rst_acc_q       <= 1'b0;
         bus.input_sel   <= '0;
         bus.neuron_sel  <= '0;
         bus.ld_acc      <= 1'b0;
         bus.ready       <= 1'b0;
         bus.done        <= 1'b0;
         bus.out_wr_en   <= 1'b0;
         bus.out_wr_addr <= '0;

         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  state     <= CLEAR;
                  n         <= '0;
                  rst_acc_q <= 1'b1;
                  bus.busy  <= 1'b1;
               end
            end
            CLEAR: begin
               state          <= ACCUM;
               k              <= '0;
               bus.ld_acc     <= 1'b1;
               bus.neuron_sel <= n;
            end
            ACCUM: begin
               if (k == SEL_W'(N - 1)) begin
                  state     <= ACTIVATE;
                  bus.ready <= 1'b1;
               end else begin
                  k              <= k + 1'b1;
                  bus.input_sel  <= k + 1'b1;
                  bus.neuron_sel <= n;
                  bus.ld_acc     <= 1'b1;
               end
            end
            ACTIVATE: begin
               state           <= WRITE;
               cap             <= bus.relu_in;
               bus.out_wr_en   <= 1'b1;
               bus.out_wr_addr <= n;
            end
            WRITE: begin
               if (n == AW'(M - 1)) begin
                  state    <= DONE;
                  bus.done <= 1'b1;
               end else begin
                  state     <= CLEAR;
                  n         <= n + 1'b1;
                  rst_acc_q <= 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               n        <= '0;
               bus.busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench: two sequencer instances (N=10,M=1 and N=3,M=4) driving
// behavioural MAC models; expected writes are queued and checked by monitors.
module tb_mac_sequencer;
   import mac_sequencer_pkg::*;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks    = 0;
   int failures  = 0;
   int cyc       = 0;
   int done_a    = 0;
   int done_b    = 0;
   int rst_acc_b = 0;
   int exp_k_b   = 0;
   int last_wr_b = 0;
   int acc_a     = 0;
   int acc_b     = 0;

   wr_t q_a[$];
   wr_t q_b[$];
   wr_t e_a;
   wr_t e_b;

   logic [7:0] x_a [16];
   logic [7:0] w_a [16];
   logic [7:0] x_b [4];
   logic [7:0] w_b [4][4];

   mac_sequencer_if #(.AW(8)) bus_a ();
   mac_sequencer_if #(.AW(8)) bus_b ();

   mac_sequencer #(.N(10), .M(1), .SHIFT(7), .AW(8)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.master)
   );

   mac_sequencer #(.N(3), .M(4), .SHIFT(7), .AW(8)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int sm(input logic [7:0] v);
      return v[7] ? -int'(v[6:0]) : int'(v[6:0]);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Behavioural MAC datapaths: memory read, multiply, accumulate, ReLU.
   always @(posedge clk) begin
      if (bus_a.rst_acc) acc_a <= 0;
      else if (bus_a.ld_acc)
         acc_a <= acc_a + sm(x_a[bus_a.input_sel[3:0]]) * sm(w_a[bus_a.input_sel[3:0]]);
      if (bus_b.rst_acc) acc_b <= 0;
      else if (bus_b.ld_acc)
         acc_b <= acc_b + sm(x_b[bus_b.input_sel[1:0]]) *
                          sm(w_b[bus_b.neuron_sel[1:0]][bus_b.input_sel[1:0]]);
   end

   assign bus_a.relu_in = (acc_a < 0) ? '0 : acc_a[19:0];
   assign bus_b.relu_in = (acc_b < 0) ? '0 : acc_b[19:0];

   always @(negedge clk) begin
      if (bus_a.out_wr_en) begin
         if (q_a.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_unexpected_write actual addr=0x%0h data=0x%0h expected no write",
                     bus_a.out_wr_addr, bus_a.out_wr_data);
         end else begin
            e_a = q_a.pop_front();
            check("a_wr_addr", 32'(bus_a.out_wr_addr), 32'(e_a.addr));
            check("a_wr_data", 32'(bus_a.out_wr_data), 32'(e_a.data));
         end
      end
      if (bus_a.done) done_a++;
   end

   always @(negedge clk) begin
      if (!rst && bus_b.rst_acc) begin
         rst_acc_b++;
         exp_k_b = 0;
      end
      if (bus_b.ld_acc) begin
         check("b_input_sel", bus_b.input_sel, 32'(exp_k_b));
         if (q_b.size() > 0) check("b_neuron_sel", 32'(bus_b.neuron_sel), 32'(q_b[0].addr));
         exp_k_b++;
      end
      if (bus_b.out_wr_en) begin
         if (q_b.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_unexpected_write actual addr=0x%0h data=0x%0h expected no write",
                     bus_b.out_wr_addr, bus_b.out_wr_data);
         end else begin
            e_b = q_b.pop_front();
            check("b_wr_addr", 32'(bus_b.out_wr_addr), 32'(e_b.addr));
            check("b_wr_data", 32'(bus_b.out_wr_data), 32'(e_b.data));
            if (e_b.addr != 8'd0) check("b_write_spacing", 32'(cyc - last_wr_b), 32'd6);
         end
         last_wr_b = cyc;
      end
      if (bus_b.done) done_b++;
   end

   task automatic set_start(input bit b, input logic v);
      if (b) bus_b.start = v;
      else   bus_a.start = v;
   endtask

   task automatic pulse_start(input bit b);
      @(negedge clk);
      set_start(b, 1'b1);
      @(negedge clk);
      set_start(b, 1'b0);
   endtask

   // Entered at the negedge that follows the start edge numbered start_cyc.
   task automatic wait_done(input bit b, input int start_cyc, input int exp_lat, input string name);
      int c = start_cyc;
      while (!(b ? bus_b.done : bus_a.done) && c < 200) begin
         @(negedge clk);
         c++;
      end
      check({name, "_latency"}, 32'(c), 32'(exp_lat));
      check({name, "_busy_in_done"}, 32'(b ? bus_b.busy : bus_a.busy), 32'd1);
   endtask

   task automatic check_idle(input bit b, input string name, input logic exp_rst_acc);
      check({name, "_rst_acc"},   32'(b ? bus_b.rst_acc : bus_a.rst_acc), 32'(exp_rst_acc));
      check({name, "_busy"},      32'(b ? bus_b.busy : bus_a.busy), 32'd0);
      check({name, "_done"},      32'(b ? bus_b.done : bus_a.done), 32'd0);
      check({name, "_ld_acc"},    32'(b ? bus_b.ld_acc : bus_a.ld_acc), 32'd0);
      check({name, "_ready"},     32'(b ? bus_b.ready : bus_a.ready), 32'd0);
      check({name, "_wr_en"},     32'(b ? bus_b.out_wr_en : bus_a.out_wr_en), 32'd0);
      check({name, "_input_sel"}, b ? bus_b.input_sel : bus_a.input_sel, 32'd0);
      check({name, "_neuron_sel"}, 32'(b ? bus_b.neuron_sel : bus_a.neuron_sel), 32'd0);
      check({name, "_wr_addr"},   32'(b ? bus_b.out_wr_addr : bus_a.out_wr_addr), 32'd0);
      check({name, "_wr_data"},   32'(b ? bus_b.out_wr_data : bus_a.out_wr_data), 32'd0);
   endtask

   task automatic run_a(input logic [7:0] x, input logic [7:0] w,
                        input logic [7:0] exp_data, input string name);
      for (int i = 0; i < 16; i++) begin
         x_a[i] = x;
         w_a[i] = w;
      end
      q_a.push_back('{addr: 8'd0, data: exp_data});
      pulse_start(1'b0);
      wait_done(1'b0, 1, 14, name);
      @(negedge clk);
      check({name, "_busy_after"}, 32'(bus_a.busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c;
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      for (int i = 0; i < 4; i++) x_b[i] = 8'h7F;
      for (int i = 0; i < 4; i++) begin
         w_b[0][i] = 8'h7F;
         w_b[1][i] = 8'h01;
         w_b[2][i] = 8'h81;
         w_b[3][i] = 8'h20;
      end

      repeat (2) @(negedge clk);
      check_idle(1'b0, "a_reset", 1'b1);
      check_idle(1'b1, "b_reset", 1'b1);
      rst = 1'b0;
      #1;
      check("a_rst_acc_released", 32'(bus_a.rst_acc), 32'd0);

      // 10 * 1 * 127 = 1270 -> 9; 10 * 127 * 127 = 161290 -> saturate; negative -> 0
      run_a(8'h01, 8'h7F, 8'h09, "a_small");
      run_a(8'h7F, 8'h7F, 8'h7F, "a_sat");
      run_a(8'h01, 8'hFF, 8'h00, "a_neg");

      // Reset in the middle of accumulation at k=5.
      pulse_start(1'b0);
      c = 0;
      while (!(bus_a.ld_acc && bus_a.input_sel == 32'd5) && c < 50) begin
         @(negedge clk);
         c++;
      end
      check("a_reach_k5", bus_a.input_sel, 32'd5);
      rst = 1'b1;
      #1;
      check("a_rst_acc_in_rst", 32'(bus_a.rst_acc), 32'd1);
      @(negedge clk);
      check_idle(1'b0, "a_after_rst", 1'b1);
      rst = 1'b0;
      #1;
      check("a_rst_acc_after_rst", 32'(bus_a.rst_acc), 32'd0);
      repeat (20) @(negedge clk);
      check("a_no_done_after_rst", 32'(done_a), 32'd3);
      check("a_idle_after_rst", 32'(bus_a.busy), 32'd0);
      run_a(8'h01, 8'h7F, 8'h09, "a_post_rst");

      // Four neurons, N=3, inputs 127: 48387->sat, 381->2, negative->0, 12192->95
      q_b.push_back('{addr: 8'd0, data: 8'h7F});
      q_b.push_back('{addr: 8'd1, data: 8'h02});
      q_b.push_back('{addr: 8'd2, data: 8'h00});
      q_b.push_back('{addr: 8'd3, data: 8'h5F});
      pulse_start(1'b1);
      @(negedge clk);
      check("b_in_accum", 32'(bus_b.ld_acc), 32'd1);
      bus_b.start = 1'b1;
      @(negedge clk);
      bus_b.start = 1'b0;
      wait_done(1'b1, 3, 25, "b_run1");

      // start held through the done cycle: ignored in DONE, accepted in IDLE
      q_b.push_back('{addr: 8'd0, data: 8'h7F});
      q_b.push_back('{addr: 8'd1, data: 8'h02});
      q_b.push_back('{addr: 8'd2, data: 8'h00});
      q_b.push_back('{addr: 8'd3, data: 8'h5F});
      bus_b.start = 1'b1;
      @(negedge clk);
      check("b_idle_after_done_start", 32'(bus_b.busy), 32'd0);
      @(negedge clk);
      bus_b.start = 1'b0;
      wait_done(1'b1, 1, 25, "b_run2");
      @(negedge clk);
      check("b_busy_after", 32'(bus_b.busy), 32'd0);

      repeat (10) @(negedge clk);
      check("a_queue_drained", 32'(q_a.size()), 32'd0);
      check("b_queue_drained", 32'(q_b.size()), 32'd0);
      check("a_done_count", 32'(done_a), 32'd4);
      check("b_done_count", 32'(done_b), 32'd2);
      check("b_rst_acc_pulses", 32'(rst_acc_b), 32'd8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Control and write-back engine for the MAC neuron datapath.
- Generates input_sel, accumulator clear/load and the activation ready strobe for a MAC instance, so the datapath runs one neuron at a time for M neurons.
- Captures each ReLU result, requantizes it to the 8-bit sign-magnitude input format, and writes it into the next layer's input memory.
- Sits between the layer-level start/done handshake and the MAC datapath; it is the writer for the memory the next MAC reads.

Parameters:
- N, 10, inputs (products) per neuron; must be >= 1.
- M, 4, neurons evaluated per start.
- SHIFT, 7, right shift applied to the ReLU result before saturation; weights are Q0.7 magnitudes.
- AW, 8, width of out_wr_addr; must satisfy 2^AW >= M.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to evaluate all M neurons; sampled only in IDLE.
- relu_in  in  20  MAC result (ReLU output), non-negative, valid while ready=1.
- input_sel  out  32  product index to input/weight memories.
- neuron_sel  out  AW  current neuron index to weight memory.
- rst_acc  out  1  accumulator clear.
- ld_acc  out  1  accumulator load enable.
- ready  out  1  activation enable to ReLU.
- busy  out  1  high from the cycle after accepted start until DONE exits.
- done  out  1  one-cycle pulse, layer complete.
- out_wr_en  out  1  next-layer input memory write strobe.
- out_wr_addr  out  AW  write address = neuron index.
- out_wr_data  out  8  sign-magnitude value {1'b0, mag[6:0]}.

Behaviour:
- Reset (synchronous): state=IDLE; all outputs 0 except rst_acc.
  - rst_acc=1 while rst=1, combinationally ORed, so the accumulator clears with the block.
  - Internal counters and the capture register are cleared.
- Reset mid-operation: same as above. No write occurs in the reset cycle. No done is generated.
- States:
  - IDLE: busy=0. start=1 -> CLEAR, with neuron counter n=0.
  - CLEAR: one cycle, rst_acc=1, input_sel=0 -> ACCUM, with k=0.
  - ACCUM: ld_acc=1, input_sel=k, neuron_sel=n, for exactly N cycles (k=0..N-1). At the k=N-1 edge -> ACTIVATE.
  - ACTIVATE: one cycle, ld_acc=0, ready=1. relu_in is registered into cap at the clock edge -> WRITE.
  - WRITE: one cycle, out_wr_en=1, out_wr_addr=n, out_wr_data=q(cap).
    - If n==M-1 -> DONE.
    - Otherwise n<=n+1 -> CLEAR.
  - DONE: one cycle, done=1, busy still 1 -> IDLE.
- Outputs are registered or decoded from state/counters only. relu_in does not feed any output combinationally.
- Per-neuron latency: N+3 cycles (CLEAR + N ACCUM + ACTIVATE + WRITE).
  - Layer latency from start edge to the done cycle: M*(N+3)+1.
- Outside the states that drive them, input_sel and neuron_sel hold 0. ld_acc, ready and out_wr_en are 0 outside their states.
- Requantization q(x):
  - s = x >> SHIFT;
  - mag = (s > 127) ? 127 : s[6:0];
  - data = {1'b0, mag}.
  - relu_in bit 19 is ignored (ReLU guarantees non-negative).
- start while busy (any state other than IDLE) is ignored; no queuing.
- start in the cycle done is high is ignored, because state is not yet IDLE. start in the following cycle is accepted.
- k and n counters do not wrap; the terminal compares are exact, which protects N=1 and M=1.

Decomposition:
- Shared package:
  - state encoding constants: IDLE, CLEAR, ACCUM, ACTIVATE, WRITE, DONE;
  - MAC_W=20, DATA_W=8 (sign-magnitude width), SEL_W=32.
- One sub-module: requant_sat (combinational shift plus saturate to 8-bit sign-magnitude), reused later by other layer write-back paths.
- FSM and counters stay in mac_sequencer.

Test Plan:
- N=10, M=1, inputs 0x01, weights 0x7F: relu 1270 -> one out_wr_en at addr 0, data 0x09; done 14 cycles after start.
- N=10, M=1, inputs 0x7F, weights 0x7F: relu 161290 -> data 0x7F (saturated).
- N=10, M=1, inputs 0x01, weights 0xFF (-127): relu 0 -> data 0x00.
- M=4, N=3: four writes at addr 0,1,2,3 spaced 6 cycles apart.
  - rst_acc pulses before each neuron.
  - input_sel sequence 0,1,2 per neuron.
  - done at cycle 25.
- start re-pulsed during ACCUM and in the done cycle: no extra writes.
  - start one cycle after done: a second full run begins.
- rst asserted during ACCUM (k=5): next cycle IDLE, all outputs 0, no write, no done, and rst_acc=1 during reset.
  - A subsequent start produces the correct result.
